// File: rtl/bus_timer_pkg.sv
// Shared definitions for the memory-mapped down-counter: FSM state codes,
// register offsets, CTRL bit layout and mode codes.
package bus_timer_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_CNT  = 2'd2;
    localparam logic [1:0] ST_INT  = 2'd3;

    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_PRESET = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;

    localparam int CTRL_W        = 4;
    localparam int CTRL_EN       = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_MODE_MSB = 2;
    localparam int CTRL_IM       = 3;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    // Codes 10/11 fall back to one-shot, so only the exact reload code counts.
    function automatic logic is_reload(input logic [CTRL_W-1:0] ctrl);
        return ctrl[CTRL_MODE_MSB:CTRL_MODE_LSB] == MODE_RELOAD;
    endfunction

endpackage

// File: rtl/bus_timer_if.sv
// Data-memory bus slice seen by the timer: word offset, write strobe/data,
// same-cycle read data and the interrupt line back to the CPU.
interface bus_timer_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 2
);
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [WIDTH-1:0]  wdata;
    logic [WIDTH-1:0]  rdata;
    logic              irq;

    modport master (output addr, we, wdata, input rdata, irq);
    modport slave  (input addr, we, wdata, output rdata, irq);
endinterface

// File: rtl/bus_timer.sv
// Programmable down-counter peripheral: CTRL/PRESET/COUNT registers, a
// four-state load/count/interrupt FSM and a combinational read mux.
module bus_timer
    import bus_timer_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 2
) (
    input  logic       clk,
    input  logic       reset,
    bus_timer_if.slave bus
);

    logic [1:0]        state_q, state_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [WIDTH-1:0]  preset_q, preset_d;
    logic [WIDTH-1:0]  count_q, count_d;
    logic              flag_q, flag_d;

    logic wr_ctrl;
    logic wr_preset;

    assign wr_ctrl   = bus.we && (bus.addr == ADDR_W'(OFF_CTRL));
    assign wr_preset = bus.we && (bus.addr == ADDR_W'(OFF_PRESET));

    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        preset_d = preset_q;
        count_d  = count_q;
        flag_d   = flag_q;

        case (state_q)
            ST_IDLE: begin
                if (ctrl_q[CTRL_EN])
                    state_d = ST_LOAD;
            end
            ST_LOAD: begin
                count_d = preset_q;
                state_d = ST_CNT;
            end
            ST_CNT: begin
                if (!ctrl_q[CTRL_EN]) begin
                    state_d = ST_IDLE;
                end else if (count_q > WIDTH'(1)) begin
                    count_d = count_q - WIDTH'(1);
                end else begin
                    // A one-shot flag goes up on the same edge that enters INT.
                    count_d = '0;
                    state_d = ST_INT;
                    if (!is_reload(ctrl_q))
                        flag_d = 1'b1;
                end
            end
            default: begin
                if (is_reload(ctrl_q)) begin
                    state_d = ST_LOAD;
                end else begin
                    ctrl_d[CTRL_EN] = 1'b0;
                    flag_d          = 1'b1;
                    state_d         = ST_IDLE;
                end
            end
        endcase

        // CPU writes come last so they beat the hardware EN-clear in INT.
        if (wr_ctrl) begin
            ctrl_d = bus.wdata[CTRL_W-1:0];
            flag_d = 1'b0;
        end
        if (wr_preset) begin
            preset_d = bus.wdata;
            flag_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            ctrl_q   <= '0;
            preset_q <= '0;
            count_q  <= '0;
            flag_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            flag_q   <= flag_d;
        end
    end

    always_comb begin
        bus.rdata = '0;
        case (bus.addr)
            ADDR_W'(OFF_CTRL):   bus.rdata = WIDTH'(ctrl_q);
            ADDR_W'(OFF_PRESET): bus.rdata = preset_q;
            ADDR_W'(OFF_COUNT):  bus.rdata = count_q;
            default:             bus.rdata = '0;
        endcase
    end

    // Reload mode pulses for the single INT cycle; one-shot holds via the flag.
    assign bus.irq = ctrl_q[CTRL_IM] &
                     (is_reload(ctrl_q) ? (state_q == ST_INT) : flag_q);

endmodule

// File: tb/tb_bus_timer.sv
// Directed bench for bus_timer: register access, one-shot and reload timing,
// masking, stop/restart, PRESET=0, COUNT write protection and mid-count reset.
module tb_bus_timer;

    localparam int WIDTH  = 32;
    localparam int ADDR_W = 2;

    logic clk = 1'b0;
    logic reset;

    int n_vec = 0;
    int n_err = 0;

    bus_timer_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

    bus_timer #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge; the write lands on the next rising edge.
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.addr  = a;
        bus.we    = 1'b1;
        bus.wdata = d;
        $display("wr  off=%0d data=0x%0h", a, d);
        @(negedge clk);
        bus.we = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
        bus.addr = a;
        bus.we   = 1'b0;
        #1;
        $display("rd  off=%0d data=0x%0h (%s)", a, bus.rdata, tag);
        chk(tag, bus.rdata, exp);
    endtask

    task automatic irq_chk(input string tag, input logic exp);
        chk(tag, {31'b0, bus.irq}, {31'b0, exp});
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        bus.addr  = '0;
        bus.we    = 1'b0;
        bus.wdata = '0;
        reset     = 1'b1;
        tick(3);
        reset = 1'b0;

        // 1: reset state
        for (int a = 0; a < 4; a++) rd_chk("t1_rd", a[1:0], 32'h0);
        irq_chk("t1_irq", 1'b0);

        // 2: one-shot, PRESET=5
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h9);
        tick(2);
        rd_chk("t2_count_e2", 2'd2, 32'd5);
        irq_chk("t2_irq_e2", 1'b0);
        tick(4);
        rd_chk("t2_count_e6", 2'd2, 32'd1);
        irq_chk("t2_irq_e6", 1'b0);
        tick(1);
        rd_chk("t2_count_e7", 2'd2, 32'd0);
        irq_chk("t2_irq_e7", 1'b1);
        tick(1);
        rd_chk("t2_ctrl_e8", 2'd0, 32'h8);
        tick(3);
        irq_chk("t2_irq_hold", 1'b1);
        wr(2'd0, 32'h8);
        irq_chk("t2_irq_clr", 1'b0);

        // 3: auto-reload, PRESET=3, period 5
        wr(2'd1, 32'd3);
        wr(2'd0, 32'hB);
        for (int e = 1; e <= 16; e++) begin
            tick(1);
            irq_chk($sformatf("t3_irq_e%0d", e), (e % 5) == 0);
        end
        rd_chk("t3_ctrl", 2'd0, 32'hB);
        wr(2'd0, 32'h0);
        tick(4);

        // 4: masked one-shot, PRESET=10
        wr(2'd1, 32'd10);
        wr(2'd0, 32'h1);
        for (int e = 1; e <= 14; e++) begin
            tick(1);
            irq_chk($sformatf("t4_irq_e%0d", e), 1'b0);
        end
        rd_chk("t4_ctrl", 2'd0, 32'h0);
        rd_chk("t4_count", 2'd2, 32'd0);
        wr(2'd0, 32'h8);
        irq_chk("t4_irq_im", 1'b0);
        tick(2);
        irq_chk("t4_irq_im2", 1'b0);

        // 5: stop at 90, then restart from a new PRESET
        wr(2'd1, 32'd100);
        wr(2'd0, 32'h1);
        tick(12);
        rd_chk("t5_count90", 2'd2, 32'd90);
        wr(2'd0, 32'h0);
        rd_chk("t5_count89", 2'd2, 32'd89);
        tick(3);
        rd_chk("t5_hold89", 2'd2, 32'd89);
        wr(2'd1, 32'd4);
        wr(2'd0, 32'h9);
        tick(2);
        rd_chk("t5_count4", 2'd2, 32'd4);
        irq_chk("t5_irq_e2", 1'b0);
        tick(3);
        rd_chk("t5_count1", 2'd2, 32'd1);
        irq_chk("t5_irq_e5", 1'b0);
        tick(1);
        rd_chk("t5_count0", 2'd2, 32'd0);
        irq_chk("t5_irq_e6", 1'b1);
        wr(2'd0, 32'h9);
        rd_chk("t5_ctrl_wins", 2'd0, 32'h9);
        irq_chk("t5_irq_wclr", 1'b0);
        wr(2'd0, 32'h0);
        tick(3);
        rd_chk("t5_stop4", 2'd2, 32'd4);
        wr(2'd2, 32'h55);
        rd_chk("t5_count_ro", 2'd2, 32'd4);
        wr(2'd3, 32'hFF);
        rd_chk("t5_off3", 2'd3, 32'h0);
        rd_chk("t5_preset", 2'd1, 32'd4);

        // 6: PRESET=0 behaves like 1; then reset mid-count
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h9);
        tick(2);
        rd_chk("t6_count_e2", 2'd2, 32'd0);
        irq_chk("t6_irq_e2", 1'b0);
        tick(1);
        irq_chk("t6_irq_e3", 1'b1);
        wr(2'd0, 32'h8);
        wr(2'd1, 32'd50);
        wr(2'd0, 32'h9);
        tick(5);
        rd_chk("t6_count47", 2'd2, 32'd47);
        wr(2'd2, 32'h1234);
        rd_chk("t6_count_ro", 2'd2, 32'd46);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        rd_chk("t6_rst_count", 2'd2, 32'd0);
        rd_chk("t6_rst_ctrl", 2'd0, 32'h0);
        rd_chk("t6_rst_preset", 2'd1, 32'd0);
        irq_chk("t6_rst_irq", 1'b0);
        tick(3);
        rd_chk("t6_idle_count", 2'd2, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
